// File: rtl/iir_fold3_datapath.sv
// Folded 2nd-order IIR datapath: one multiplier and one adder shared across phases 0,1,2.
// Latency: x_in sampled at the phase-0 edge, y_out/y_valid two edges later; no backpressure.
module iir_fold3_datapath #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int FRAC   = 14,
  parameter int ACC_W  = DATA_W + COEF_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               phase,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     x_valid,
  input  logic signed [COEF_W-1:0] coef_b0,
  input  logic signed [COEF_W-1:0] coef_a1,
  input  logic signed [COEF_W-1:0] coef_a2,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_valid,
  output logic                     phase_err
);

  localparam int PROD_W = COEF_W + DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_y1;
  logic signed [DATA_W-1:0] r_y2;
  logic signed [DATA_W-1:0] r_y_out;
  logic signed [COEF_W-1:0] r_a1;
  logic signed [COEF_W-1:0] r_a2;
  logic                     r_y_valid;
  logic                     r_phase_err;
  logic                     r_frame_active;
  logic [1:0]               r_exp_phase;

  logic signed [COEF_W-1:0] w_mul_c;
  logic signed [DATA_W-1:0] w_mul_d;
  logic signed [PROD_W-1:0] w_mul_c_ext;
  logic signed [PROD_W-1:0] w_mul_d_ext;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_add_a;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_shift;
  logic signed [DATA_W-1:0] w_sat;

  // Operand select: phase 0 b0*x (fresh accumulation), phase 1 a1*y1, phase 2 a2*y2.
  always_comb begin
    w_mul_c = coef_b0;
    w_mul_d = x_in;
    w_add_a = '0;
    case (phase)
      2'd1: begin
        w_mul_c = r_a1;
        w_mul_d = r_y1;
        w_add_a = r_acc;
      end
      2'd2: begin
        w_mul_c = r_a2;
        w_mul_d = r_y2;
        w_add_a = r_acc;
      end
      default: ;
    endcase
  end

  assign w_mul_c_ext = {{DATA_W{w_mul_c[COEF_W-1]}}, w_mul_c};
  assign w_mul_d_ext = {{COEF_W{w_mul_d[DATA_W-1]}}, w_mul_d};
  assign w_prod      = w_mul_c_ext * w_mul_d_ext;
  assign w_prod_ext  = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_sum       = w_add_a + w_prod_ext;
  assign w_shift     = w_sum >>> FRAC;

  always_comb begin
    w_sat = w_shift[DATA_W-1:0];
    if (w_shift > SAT_MAX)
      w_sat = SAT_MAX[DATA_W-1:0];
    else if (w_shift < SAT_MIN)
      w_sat = SAT_MIN[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc          <= '0;
      r_y1           <= '0;
      r_y2           <= '0;
      r_y_out        <= '0;
      r_a1           <= '0;
      r_a2           <= '0;
      r_y_valid      <= 1'b0;
      r_phase_err    <= 1'b0;
      r_frame_active <= 1'b0;
      r_exp_phase    <= 2'd0;
    end else begin
      r_y_valid <= 1'b0;
      case (phase)
        2'd0: begin
          // An active frame never expects phase 0, so seeing it here is a sequence violation.
          if (r_frame_active)
            r_phase_err <= 1'b1;
          if (x_valid) begin
            r_a1           <= coef_a1;
            r_a2           <= coef_a2;
            r_acc          <= w_sum;
            r_frame_active <= 1'b1;
            r_exp_phase    <= 2'd1;
          end else begin
            r_frame_active <= 1'b0;
            r_exp_phase    <= 2'd0;
          end
        end
        2'd1: begin
          if (r_frame_active) begin
            if (r_exp_phase == 2'd1) begin
              r_acc       <= w_sum;
              r_exp_phase <= 2'd2;
            end else begin
              r_phase_err    <= 1'b1;
              r_frame_active <= 1'b0;
              r_exp_phase    <= 2'd0;
            end
          end
        end
        2'd2: begin
          if (r_frame_active) begin
            if (r_exp_phase == 2'd2) begin
              r_y_out   <= w_sat;
              r_y1      <= w_sat;
              r_y2      <= r_y1;
              r_y_valid <= 1'b1;
            end else begin
              r_phase_err <= 1'b1;
            end
            r_frame_active <= 1'b0;
            r_exp_phase    <= 2'd0;
          end
        end
        default: begin
          r_phase_err    <= 1'b1;
          r_frame_active <= 1'b0;
          r_exp_phase    <= 2'd0;
        end
      endcase
    end
  end

  assign y_out     = r_y_out;
  assign y_valid   = r_y_valid;
  assign phase_err = r_phase_err;

endmodule

// File: tb/tb_iir_fold3_datapath.sv
// Bench for iir_fold3_datapath: directed vector table followed by randomized frames vs. a frame-level model.
module tb_iir_fold3_datapath;

  logic               clk;
  logic               rst_n;
  logic [1:0]         phase;
  logic signed [15:0] x_in;
  logic               x_valid;
  logic signed [15:0] coef_b0;
  logic signed [15:0] coef_a1;
  logic signed [15:0] coef_a2;
  logic signed [15:0] y_out;
  logic               y_valid;
  logic               phase_err;

  int n_cmp;
  int n_bad;

  iir_fold3_datapath dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .phase     (phase),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .coef_b0   (coef_b0),
    .coef_a1   (coef_a1),
    .coef_a2   (coef_a2),
    .y_out     (y_out),
    .y_valid   (y_valid),
    .phase_err (phase_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst;
    int ph;
    bit xv;
    int x;
    int b0;
    int a1;
    int a2;
    int ey;
    bit ev;
    bit ee;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rst, int ph, bit xv, int x, int b0, int a1, int a2,
                              int ey, bit ev, bit ee);
    vec_t v;
    v.rst = rst; v.ph = ph; v.xv = xv; v.x = x;
    v.b0 = b0; v.a1 = a1; v.a2 = a2;
    v.ey = ey; v.ev = ev; v.ee = ee;
    vecs.push_back(v);
  endfunction

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit rst, int ph, bit xv, int x, int b0, int a1, int a2);
    @(negedge clk);
    rst_n   = rst;
    phase   = 2'(ph);
    x_valid = xv;
    x_in    = 16'(x);
    coef_b0 = 16'(b0);
    coef_a1 = 16'(a1);
    coef_a2 = 16'(a2);
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: whole-formula evaluation once a frame completes.
  int  m_y1, m_y2, m_yout;
  bit  m_err, m_vld, m_in_frame;
  int  m_next;
  int  m_x, m_b0, m_a1, m_a2;

  function automatic int sat_shift(longint s);
    longint q;
    q = s >>> 14;
    if (q > 32767) return 32767;
    if (q < -32768) return -32768;
    return int'(q);
  endfunction

  function automatic void model_reset();
    m_y1 = 0; m_y2 = 0; m_yout = 0;
    m_err = 0; m_vld = 0; m_in_frame = 0; m_next = 0;
  endfunction

  function automatic void model_step(int ph, bit xv, int x, int b0, int a1, int a2);
    longint s;
    int y;
    m_vld = 0;
    if (ph == 3) begin
      m_err = 1;
      m_in_frame = 0;
    end else if (ph == 0) begin
      if (m_in_frame) m_err = 1;
      m_in_frame = xv;
      if (xv) begin
        m_x = x; m_b0 = b0; m_a1 = a1; m_a2 = a2; m_next = 1;
      end
    end else if (m_in_frame) begin
      if (ph != m_next) begin
        m_err = 1;
        m_in_frame = 0;
      end else if (ph == 1) begin
        m_next = 2;
      end else begin
        s = longint'(m_b0) * m_x + longint'(m_a1) * m_y1 + longint'(m_a2) * m_y2;
        y = sat_shift(s);
        m_y2 = m_y1;
        m_y1 = y;
        m_yout = y;
        m_vld = 1;
        m_in_frame = 0;
      end
    end
  endfunction

  function automatic int rnd_signed(int mag);
    int r;
    r = int'($urandom_range(0, 2 * mag)) - mag;
    return r;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0; phase = 2'd0; x_valid = 1'b0; x_in = '0;
    coef_b0 = '0; coef_a1 = '0; coef_a2 = '0;

    //  rst ph xv  x      b0     a1    a2     ey     ev ee
    add(0, 0, 1, 1234,  16384, 100,  100,   0,     0, 0); // reset state
    // passthrough
    add(1, 0, 1, 1000,  16384, 0,    0,     0,     0, 0);
    add(1, 1, 0, 0,     0,     0,    0,     0,     0, 0);
    add(1, 2, 0, 0,     0,     0,    0,     1000,  1, 0);
    add(1, 0, 1, -1234, 16384, 0,    0,     1000,  0, 0);
    add(1, 1, 0, 0,     0,     0,    0,     1000,  0, 0);
    add(1, 2, 0, 0,     0,     0,    0,     -1234, 1, 0);
    add(0, 0, 0, 0,     0,     0,    0,     0,     0, 0);
    // impulse decay; later a1 changes at phase 1/2 must not disturb the latched value
    add(1, 0, 1, 1000,  16384, 8192, 0,     0,     0, 0);
    add(1, 1, 0, 0,     0,     -999, 777,   0,     0, 0);
    add(1, 2, 0, 0,     0,     -999, 777,   1000,  1, 0);
    add(1, 0, 1, 0,     16384, 8192, 0,     1000,  0, 0);
    add(1, 1, 0, 0,     0,     5,    5,     1000,  0, 0);
    add(1, 2, 0, 0,     0,     5,    5,     500,   1, 0);
    add(1, 0, 1, 0,     16384, 8192, 0,     500,   0, 0);
    add(1, 1, 0, 0,     0,     0,    0,     500,   0, 0);
    add(1, 2, 0, 0,     0,     0,    0,     250,   1, 0);
    add(1, 0, 1, 0,     16384, 8192, 0,     250,   0, 0);
    add(1, 1, 0, 0,     0,     0,    0,     250,   0, 0);
    add(1, 2, 0, 0,     0,     0,    0,     125,   1, 0);
    // saturation
    add(1, 0, 1, 30000, 32767, 0,    0,     125,   0, 0);
    add(1, 1, 0, 0,     0,     0,    0,     125,   0, 0);
    add(1, 2, 0, 0,     0,     0,    0,     32767, 1, 0);
    add(1, 0, 1, -30000,32767, 0,    0,     32767, 0, 0);
    add(1, 1, 0, 0,     0,     0,    0,     32767, 0, 0);
    add(1, 2, 0, 0,     0,     0,    0,     -32768,1, 0);
    // sequence violation 0,1,0: new frame completes, history untouched by the aborted one
    add(1, 0, 1, 700,   16384, 0,    0,     -32768,0, 0);
    add(1, 1, 0, 0,     0,     0,    0,     -32768,0, 0);
    add(1, 0, 1, 300,   16384, 0,    0,     -32768,0, 1);
    add(1, 1, 0, 0,     0,     0,    0,     -32768,0, 1);
    add(1, 2, 0, 0,     0,     0,    0,     300,   1, 1);
    add(1, 0, 1, 0,     0,     8192, 0,     300,   0, 1);
    add(1, 1, 0, 0,     0,     0,    0,     300,   0, 1);
    add(1, 2, 0, 0,     0,     0,    0,     150,   1, 1);
    // idle gap, then a frame reading y2 from before the gap
    add(1, 0, 0, 5000,  16384, 0,    0,     150,   0, 1);
    add(1, 1, 0, 0,     0,     0,    0,     150,   0, 1);
    add(1, 2, 0, 0,     0,     0,    0,     150,   0, 1);
    add(1, 0, 1, 9999,  0,     0,    16384, 150,   0, 1);
    add(1, 1, 0, 0,     0,     0,    0,     150,   0, 1);
    add(1, 2, 0, 0,     0,     0,    0,     300,   1, 1);
    // phase 3 from clean reset
    add(0, 0, 0, 0,     0,     0,    0,     0,     0, 0);
    add(1, 3, 0, 0,     0,     0,    0,     0,     0, 1);
    add(1, 0, 1, 2000,  16384, 0,    0,     0,     0, 1);
    add(1, 1, 0, 0,     0,     0,    0,     0,     0, 1);
    add(1, 2, 0, 0,     0,     0,    0,     2000,  1, 1);
    // mid-frame reset, then passthrough with zero history
    add(1, 0, 1, 777,   16384, 0,    0,     2000,  0, 1);
    add(0, 1, 0, 0,     0,     0,    0,     0,     0, 0);
    add(1, 2, 0, 0,     0,     0,    0,     0,     0, 0);
    add(1, 0, 1, 500,   16384, 16384,16384, 0,     0, 0);
    add(1, 1, 0, 0,     0,     0,    0,     0,     0, 0);
    add(1, 2, 0, 0,     0,     0,    0,     500,   1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ph, vecs[i].xv, vecs[i].x,
            vecs[i].b0, vecs[i].a1, vecs[i].a2);
      check($sformatf("vec%0d y_out", i), int'(y_out), vecs[i].ey);
      check($sformatf("vec%0d y_valid", i), int'(y_valid), int'(vecs[i].ev));
      check($sformatf("vec%0d phase_err", i), int'(phase_err), int'(vecs[i].ee));
    end

    // Randomized run: mostly legal phase sequences with sporadic illegal phases and resets.
    begin
      int gen_ph;
      int ph;
      bit xv, rst;
      int x, b0, a1, a2;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_reset();
      gen_ph = 0;
      for (int c = 0; c < 1500; c++) begin
        ph = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 3)) : gen_ph;
        rst = ($urandom_range(0, 299) != 0);
        xv = ($urandom_range(0, 9) != 0);
        x  = rnd_signed(32767);
        b0 = rnd_signed(20000);
        a1 = rnd_signed(12000);
        a2 = rnd_signed(8000);
        drive(rst, ph, xv, x, b0, a1, a2);
        if (!rst) model_reset();
        else model_step(ph, xv, x, b0, a1, a2);
        gen_ph = (ph >= 2) ? 0 : ph + 1;
        check("rnd y_out", int'(y_out), m_yout);
        check("rnd y_valid", int'(y_valid), int'(m_vld));
        check("rnd phase_err", int'(phase_err), int'(m_err));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
